// File: rtl/img2col_top.sv
// Streaming image-to-column converter: buffers one band of K rows,
// then replays every non-overlapping KxK window of the band R times.
module img2col_top #(
  parameter int DATA_WIDTH  = 64,
  parameter int MAX_KERNEL  = 16,
  parameter int MAX_IN_SIZE = 224
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sData_valid,
  output logic                  sData_ready,
  input  logic [DATA_WIDTH-1:0] sData_payload,
  input  logic [7:0]            Stride,
  input  logic [7:0]            Kernel_Size,
  input  logic [7:0]            Window_Size,
  input  logic [15:0]           InFeature_Size,
  input  logic [15:0]           InFeature_Channel,
  input  logic [15:0]           OutFeature_Channel,
  input  logic [15:0]           OutFeature_Channel_Count_Times,
  input  logic [15:0]           OutFeature_Size,
  input  logic [15:0]           OutCol_Count_Times,
  input  logic [15:0]           OutRow_Count_Times,
  input  logic [15:0]           InCol_Count_Times,
  output logic [DATA_WIDTH-1:0] mData,
  output logic                  mValid,
  output logic                  mLast,
  output logic                  Test_Signal,
  input  logic [15:0]           Test_Generate_Period
);

  localparam int DEPTH = MAX_KERNEL * MAX_IN_SIZE;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_EMIT
  } state_t;

  state_t state_q, state_d;

  logic [15:0] band_q, band_d;
  logic [15:0] wr_row_q, wr_row_d;
  logic [15:0] wr_col_q, wr_col_d;
  logic [15:0] rd_g_q, rd_g_d;
  logic [15:0] rd_p_q, rd_p_d;
  logic [15:0] rd_base_q, rd_base_d;
  logic [15:0] rd_r_q, rd_r_d;
  logic [15:0] rd_c_q, rd_c_d;

  logic valid_q, valid_d;
  logic last_q, last_d;
  logic tag_q, tag_d;
  logic [DATA_WIDTH-1:0] data_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [15:0] k16, s16;
  logic        wr_fire, wr_row_end, fill_done;
  logic        rd_en, c_end, r_end, p_end, g_end;
  logic        rd_last, band_last;
  logic [AW-1:0] wr_addr, rd_addr;

  logic unused;
  assign unused = ^{Window_Size, InFeature_Size,
                    InFeature_Channel, OutFeature_Channel,
                    OutCol_Count_Times};

  assign k16 = {8'd0, Kernel_Size};
  assign s16 = {8'd0, Stride};

  assign wr_fire    = sData_valid && (state_q == S_FILL);
  assign wr_row_end = wr_col_q == InCol_Count_Times - 16'd1;
  assign fill_done  = wr_fire && wr_row_end
                   && (wr_row_q == k16 - 16'd1);

  assign rd_en = state_q == S_EMIT;
  assign c_end = rd_c_q == k16 - 16'd1;
  assign r_end = rd_r_q == k16 - 16'd1;
  assign p_end = rd_p_q == OutFeature_Size - 16'd1;
  assign g_end = rd_g_q
              == OutFeature_Channel_Count_Times - 16'd1;

  assign rd_last   = rd_en && c_end && r_end && p_end && g_end;
  assign band_last = (band_q + 16'd1) == OutRow_Count_Times;

  // Each kernel row owns a fixed MAX_IN_SIZE slice of the buffer
  assign wr_addr = AW'(wr_row_q) * AW'(MAX_IN_SIZE)
                 + AW'(wr_col_q);
  assign rd_addr = AW'(rd_r_q) * AW'(MAX_IN_SIZE)
                 + AW'(rd_base_q) + AW'(rd_c_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FILL;
      S_FILL: if (fill_done) state_d = S_EMIT;
      S_EMIT: begin
        if (rd_last) begin
          state_d = band_last ? S_IDLE : S_FILL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sData_ready = state_q == S_FILL;
    valid_d     = rd_en;
    last_d      = rd_last && band_last;
    tag_d       = rd_en && (rd_g_q == 16'd0)
               && ((band_q + 16'd1) == Test_Generate_Period);
  end

  always_comb begin
    band_d    = band_q;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    rd_g_d    = rd_g_q;
    rd_p_d    = rd_p_q;
    rd_base_d = rd_base_q;
    rd_r_d    = rd_r_q;
    rd_c_d    = rd_c_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          band_d    = '0;
          wr_row_d  = '0;
          wr_col_d  = '0;
          rd_g_d    = '0;
          rd_p_d    = '0;
          rd_base_d = '0;
          rd_r_d    = '0;
          rd_c_d    = '0;
        end
      end
      S_FILL: begin
        if (wr_fire) begin
          if (wr_row_end) begin
            wr_col_d = '0;
            wr_row_d = fill_done ? '0 : wr_row_q + 16'd1;
          end else begin
            wr_col_d = wr_col_q + 16'd1;
          end
        end
      end
      S_EMIT: begin
        rd_c_d = rd_c_q + 16'd1;
        if (c_end) begin
          rd_c_d = '0;
          rd_r_d = rd_r_q + 16'd1;
          if (r_end) begin
            rd_r_d    = '0;
            rd_p_d    = rd_p_q + 16'd1;
            rd_base_d = rd_base_q + s16;
            if (p_end) begin
              rd_p_d    = '0;
              rd_base_d = '0;
              rd_g_d    = rd_g_q + 16'd1;
              if (g_end) begin
                rd_g_d = '0;
                band_d = band_q + 16'd1;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      band_q    <= '0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      rd_g_q    <= '0;
      rd_p_q    <= '0;
      rd_base_q <= '0;
      rd_r_q    <= '0;
      rd_c_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      tag_q     <= 1'b0;
    end else begin
      band_q    <= band_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      rd_g_q    <= rd_g_d;
      rd_p_q    <= rd_p_d;
      rd_base_q <= rd_base_d;
      rd_r_q    <= rd_r_d;
      rd_c_q    <= rd_c_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      tag_q     <= tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr] <= sData_payload;
    end
  end

  // Synchronous read port; output register clears on reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
    end else if (rd_en) begin
      data_q <= mem[rd_addr];
    end
  end

  assign mData       = data_q;
  assign mValid      = valid_q;
  assign mLast       = last_q;
  assign Test_Signal = tag_q;

endmodule

// File: tb/tb_img2col_top.sv
// Self-checking bench for img2col_top: table of frame configs checked
// against a window-order reference model, plus restart/reset sequences.
module tb_img2col_top;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_payload = '0;
  logic [7:0]  k_s = 8'd2;
  logic [15:0] w_s = 16'd4;
  logic [15:0] p_s = 16'd2;
  logic [15:0] b_s = 16'd2;
  logic [15:0] r_s = 16'd1;
  logic [15:0] tgp_s = 16'd0;
  logic [63:0] m_data;
  logic        m_valid, m_last, t_sig;

  always #5 clk = ~clk;

  img2col_top dut (
    .clk                           (clk),
    .reset                         (reset),
    .start                         (start),
    .sData_valid                   (s_valid),
    .sData_ready                   (s_ready),
    .sData_payload                 (s_payload),
    .Stride                        (k_s),
    .Kernel_Size                   (k_s),
    .Window_Size                   (k_s),
    .InFeature_Size                (16'(b_s * k_s)),
    .InFeature_Channel             (16'd8),
    .OutFeature_Channel            (16'd8),
    .OutFeature_Channel_Count_Times(r_s),
    .OutFeature_Size               (p_s),
    .OutCol_Count_Times            (p_s),
    .OutRow_Count_Times            (b_s),
    .InCol_Count_Times             (w_s),
    .mData                         (m_data),
    .mValid                        (m_valid),
    .mLast                         (m_last),
    .Test_Signal                   (t_sig),
    .Test_Generate_Period          (tgp_s)
  );

  typedef struct {
    int k, w, p, b, r, tgp, vpct;
    bit restart, sie, seq;
    int exp_in, exp_out;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    bit last;
    bit tag;
  } ow_t;

  int errors = 0;
  int checks = 0;

  vec_t        tbl [9];
  logic [63:0] img [$];
  ow_t         exp_q [$];
  logic [63:0] got [$];
  logic [63:0] seq_exp [16] = '{0, 1, 4, 5, 2, 3, 6, 7,
                                8, 9, 12, 13, 10, 11, 14, 15};

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, act, req);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    k_s   = 8'(v.k);
    w_s   = 16'(v.w);
    p_s   = 16'(v.p);
    b_s   = 16'(v.b);
    r_s   = 16'(v.r);
    tgp_s = 16'(v.tgp);
  endtask

  task automatic build_model(input vec_t v);
    img.delete();
    exp_q.delete();
    got.delete();
    for (int i = 0; i < v.b * v.k * v.w; i++) begin
      if (v.seq) img.push_back(64'(i));
      else img.push_back({$urandom(), $urandom()});
    end
    for (int b = 0; b < v.b; b++)
      for (int g = 0; g < v.r; g++)
        for (int p = 0; p < v.p; p++)
          for (int r = 0; r < v.k; r++)
            for (int c = 0; c < v.k; c++) begin
              ow_t o;
              o.d    = img[(b * v.k + r) * v.w + p * v.k + c];
              o.last = (b == v.b - 1) && (g == v.r - 1)
                    && (p == v.p - 1) && (r == v.k - 1)
                    && (c == v.k - 1);
              o.tag  = (b + 1 == v.tgp) && (g == 0);
              exp_q.push_back(o);
            end
  endtask

  task automatic run_frame(input vec_t v, input bit do_start,
                           input int abort_after);
    int  idx = 0, nout = 0, cyc = 0, gap = 0, extra = 0;
    int  emit_len = v.r * v.p * v.k * v.k;
    int  budget = 20 * (v.exp_in + v.exp_out) + 500;
    bit  seen_hi = 0, done = 0, sie_done = 0;
    ow_t e;
    set_cfg(v);
    build_model(v);
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", m_data, e.d);
          chk("last", 64'(m_last), 64'(e.last));
          chk("tag", 64'(t_sig), 64'(e.tag));
        end
        got.push_back(m_data);
        nout++;
        if (m_last) done = 1;
      end else if (m_last || t_sig) begin
        chk("stray_flag", {62'd0, m_last, t_sig}, 0);
      end
      if (s_ready) begin
        if (seen_hi && gap > 0) chk("ready_gap", 64'(gap), 64'(emit_len));
        gap = 0;
        seen_hi = 1;
      end else if (seen_hi) begin
        gap++;
      end
      start = do_start && (cyc == 1);
      if (v.restart && m_valid && m_last) start = 1'b1;
      if (v.sie && !sie_done && seen_hi && !s_ready) begin
        start = 1'b1;
        sie_done = 1;
      end
      if (idx < img.size()) begin
        s_valid = ($urandom_range(99) < v.vpct);
        s_payload = img[idx];
      end else begin
        s_valid = 1'b1;
        s_payload = {$urandom(), $urandom()};
      end
      if (s_valid && s_ready) begin
        if (idx < img.size()) idx++;
        else extra++;
      end
      if (abort_after > 0 && nout == abort_after) begin
        reset = 1'b0;
        start = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(m_valid), 0);
        chk("rst_last", 64'(m_last), 0);
        chk("rst_tag", 64'(t_sig), 0);
        chk("rst_data", m_data, 0);
        chk("rst_ready", 64'(s_ready), 0);
        reset = 1'b1;
        return;
      end
      if (cyc > budget) begin
        chk("timeout", 64'(nout), 64'(v.exp_out));
        return;
      end
    end
    chk("words_out", 64'(nout), 64'(v.exp_out));
    chk("words_in", 64'(idx), 64'(v.exp_in));
    chk("extra_accepted", 64'(extra), 0);
    chk("model_left", 64'(exp_q.size()), 0);
  endtask

  initial begin
    int acc;
    // k, w, p, b, r, tgp, vpct, restart, sie, seq, in, out
    tbl[0] = '{2, 4, 2, 2, 1, 0, 100, 1, 0, 1, 16, 16};
    tbl[1] = '{2, 4, 2, 2, 1, 0, 100, 0, 0, 1, 16, 16};
    tbl[2] = '{2, 4, 2, 2, 3, 1, 100, 0, 1, 0, 16, 48};
    tbl[3] = '{2, 4, 2, 2, 2, 2, 70, 0, 0, 0, 16, 32};
    tbl[4] = '{3, 6, 2, 2, 1, 0, 50, 0, 0, 0, 36, 36};
    tbl[5] = '{1, 3, 3, 2, 2, 1, 60, 0, 0, 0, 6, 12};
    tbl[6] = '{5, 20, 4, 3, 2, 3, 80, 0, 0, 0, 300, 600};
    tbl[7] = '{8, 224, 28, 1, 1, 1, 90, 0, 0, 0, 1792, 1792};
    tbl[8] = '{16, 32, 2, 1, 1, 1, 100, 0, 0, 0, 512, 512};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_valid", 64'(m_valid), 0);
    chk("init_last", 64'(m_last), 0);
    chk("init_tag", 64'(t_sig), 0);
    chk("init_data", m_data, 0);
    chk("init_ready", 64'(s_ready), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i], (i == 0) || !tbl[i-1].restart, 0);
      if (tbl[i].seq) begin
        chk("seq_len", 64'(got.size()), 16);
        for (int j = 0; j < 16 && j < got.size(); j++)
          chk("seq_word", got[j], seq_exp[j]);
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);

    run_frame(tbl[6], 1, 50);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      if (s_ready || m_valid) acc++;
    end
    s_valid = 1'b0;
    chk("post_reset_idle", 64'(acc), 0);
    run_frame(tbl[6], 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
